// File: rtl/booth_step_div_if.sv
// booth_step_div_if
//   Request/result bundle between a requester and the booth_step_div
//   restoring divider.
//
//   Requester -> divider : start, sgn, dividend[7:0], divisor[7:0]
//   Divider -> requester : busy, done, quotient[7:0], remainder[7:0],
//                          div_by_zero
//
//   master modport: the requester (ALU sequencer or testbench)
//   slave modport : the divider itself
interface booth_step_div_if;
  logic       start;
  logic       sgn;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, sgn, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, sgn, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/booth_step_div.sv
// booth_step_div
//   Sequential 8-bit restoring divider, one shift-subtract step per clock.
//   A start pulse in IDLE captures the operands; eight CALC cycles produce
//   the quotient/remainder; FIN registers the results and pulses done.
//   Fixed latency: done rises 9 cycles after the accepting edge.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    booth_step_div_if.slave
//              start/sgn/dividend/divisor in,
//              busy/done/quotient/remainder/div_by_zero out
//
//   Configuration macro: SIGNED_DIV_EN
//     defined   -> sgn=1 performs truncating two's-complement division
//     undefined -> sgn is ignored, unsigned only, no sign logic built
module booth_step_div (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_step_div_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [8:0] a_q, a_d;
  logic [7:0] q_q, q_d;
  logic [7:0] m_q, m_d;
  logic [7:0] raw_q, raw_d;
  logic       dz_q, dz_d;
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       div_by_zero_q, div_by_zero_d;
  logic       done_q, done_d;

  logic [7:0] dvd_mag;
  logic [7:0] dvs_mag;
  logic [7:0] quo_fin;
  logic [7:0] rem_fin;

  // One restoring step: shift {A,Q} left, trial-subtract M, keep the
  // difference only when it did not borrow.
  logic [8:0] a_sh;
  logic [7:0] q_sh;
  logic [8:0] t;

  assign a_sh = {a_q[7:0], q_q[7]};
  assign q_sh = {q_q[6:0], 1'b0};
  assign t    = a_sh - {1'b0, m_q};

  // A never exceeds M-1 between steps, so its top bit is always clear.
  logic unused_a_msb;
  assign unused_a_msb = a_q[8];

`ifdef SIGNED_DIV_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic dvd_neg, dvs_neg;

  assign dvd_neg = bus.sgn & bus.dividend[7];
  assign dvs_neg = bus.sgn & bus.divisor[7];
  // -128 negates to 8'h80, which is 128 when read as unsigned.
  assign dvd_mag = dvd_neg ? (~bus.dividend + 8'd1) : bus.dividend;
  assign dvs_mag = dvs_neg ? (~bus.divisor + 8'd1) : bus.divisor;
  assign quo_fin = neg_quo_q ? (~q_q + 8'd1) : q_q;
  assign rem_fin = neg_rem_q ? (~a_q[7:0] + 8'd1) : a_q[7:0];

  // Sign corrections are decided at load and applied at FIN.
  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (state_q == IDLE && bus.start) begin
      neg_quo_d = dvd_neg ^ dvs_neg;
      neg_rem_d = dvd_neg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = bus.sgn;
  assign dvd_mag    = bus.dividend;
  assign dvs_mag    = bus.divisor;
  assign quo_fin    = q_q;
  assign rem_fin    = a_q[7:0];
`endif

  // Controller and datapath next-state. The raw dividend is kept so a
  // divide-by-zero can return it unchanged as the remainder.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    q_d           = q_q;
    m_d           = m_q;
    raw_d         = raw_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = 9'd0;
          q_d     = dvd_mag;
          m_d     = dvs_mag;
          raw_d   = bus.dividend;
          dz_d    = (bus.divisor == 8'd0);
          cnt_d   = 3'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (t[8]) begin
          a_d = a_sh;
          q_d = q_sh;
        end else begin
          a_d = t;
          q_d = {q_sh[7:1], 1'b1};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = FIN;
        end
      end
      FIN: begin
        if (dz_q) begin
          quotient_d  = 8'hFF;
          remainder_d = raw_q;
        end else begin
          quotient_d  = quo_fin;
          remainder_d = rem_fin;
        end
        div_by_zero_d = dz_q;
        done_d        = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      a_q           <= 9'd0;
      q_q           <= 8'd0;
      m_q           <= 8'd0;
      raw_q         <= 8'd0;
      dz_q          <= 1'b0;
      quotient_q    <= 8'd0;
      remainder_q   <= 8'd0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      q_q           <= q_d;
      m_q           <= m_d;
      raw_q         <= raw_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  // busy covers CALC and FIN, i.e. the nine cycles after acceptance.
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule
